// File: rtl/simt_branch_ctrl.sv
// SIMT warp branch controller: resolves per-thread branches and drives an external divergence stack.
// Define SIMT_BRANCH_STATS_EN to enable the saturating divergence/reconvergence counters.
module simt_branch_ctrl #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  parameter int STACK_DEPTH       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         br_valid,
  input  logic [PC_BITS-1:0]           br_target,
  input  logic [PC_BITS-1:0]           br_reconv,
  input  logic [THREADS_PER_BLOCK-1:0] br_taken,
  input  logic                         adv_valid,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [PC_BITS-1:0]           stk_push_pc,
  output logic [PC_BITS-1:0]           stk_push_reconvpc,
  output logic [THREADS_PER_BLOCK-1:0] stk_push_mask,
  input  logic [PC_BITS-1:0]           stk_tos_pc,
  input  logic [PC_BITS-1:0]           stk_tos_reconvpc,
  input  logic [THREADS_PER_BLOCK-1:0] stk_tos_mask,
  output logic [PC_BITS-1:0]           pc,
  output logic [THREADS_PER_BLOCK-1:0] active_mask,
  output logic                         ready,
  output logic                         diverged,
  output logic                         err_overflow,
  output logic [15:0]                  div_count,
  output logic [15:0]                  reconv_count
);
  localparam int T     = THREADS_PER_BLOCK;
  localparam int P     = PC_BITS;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PUSH_JOIN, PUSH_FALL, CHECK} state_t;

  state_t           state;
  logic [P-1:0]     cur_reconv;
  logic [P-1:0]     target_q;
  logic [P-1:0]     reconv_q;
  logic [T-1:0]     eff_q;
  logic [CNT_W-1:0] cnt;

  logic [T-1:0] eff;
  logic [P-1:0] pc_inc;
  logic         overflow;
  logic         do_pop;

  assign eff      = br_taken & active_mask;
  assign pc_inc   = pc + P'(1);
  // A divergent branch needs two free entries; otherwise it is treated as an overflow.
  assign overflow = (int'(cnt) + 2) > STACK_DEPTH;
  assign do_pop   = (state == CHECK) && (pc == cur_reconv) && (cnt != '0);

  assign ready    = (state == IDLE);
  assign diverged = (cnt != '0);
  assign stk_push = (state == PUSH_JOIN) || (state == PUSH_FALL);
  assign stk_pop  = do_pop;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    stk_push_pc       = '0;
    stk_push_mask     = '0;
    stk_push_reconvpc = '0;
    if (state == PUSH_JOIN) begin
      stk_push_pc       = reconv_q;
      stk_push_mask     = active_mask;
      stk_push_reconvpc = cur_reconv;
    end else if (state == PUSH_FALL) begin
      stk_push_pc       = pc_inc;
      stk_push_mask     = active_mask & ~eff_q;
      stk_push_reconvpc = reconv_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      active_mask  <= '1;
      cur_reconv   <= '1;
      cnt          <= '0;
      err_overflow <= 1'b0;
      target_q     <= '0;
      reconv_q     <= '0;
      eff_q        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (br_valid) begin
            if (eff == active_mask) begin
              pc    <= br_target;
              state <= CHECK;
            end else if (eff == '0) begin
              pc    <= pc_inc;
              state <= CHECK;
            end else if (overflow) begin
              err_overflow <= 1'b1;
              pc           <= br_target;
              state        <= CHECK;
            end else begin
              target_q <= br_target;
              reconv_q <= br_reconv;
              eff_q    <= eff;
              state    <= PUSH_JOIN;
            end
          end else if (adv_valid) begin
            pc    <= pc_inc;
            state <= CHECK;
          end
        end
        PUSH_JOIN: begin
          cnt   <= cnt + CNT_W'(1);
          state <= PUSH_FALL;
        end
        PUSH_FALL: begin
          cnt         <= cnt + CNT_W'(1);
          pc          <= target_q;
          active_mask <= eff_q;
          cur_reconv  <= reconv_q;
          state       <= CHECK;
        end
        CHECK: begin
          // Stay here after a pop: the restored context may itself sit at its reconvergence PC.
          if (do_pop) begin
            pc          <= stk_tos_pc;
            active_mask <= stk_tos_mask;
            cur_reconv  <= stk_tos_reconvpc;
            cnt         <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIMT_BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      div_count    <= '0;
      reconv_count <= '0;
    end else begin
      if (state == PUSH_FALL && div_count != 16'hFFFF)
        div_count <= div_count + 16'd1;
      if (do_pop && reconv_count != 16'hFFFF)
        reconv_count <= reconv_count + 16'd1;
    end
  end
`else
  assign div_count    = '0;
  assign reconv_count = '0;
`endif

endmodule
